// File: rtl/sum_arb_pkg.sv
// Shared types and the round-robin search helper for the shared summing arbiter.
package sum_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RSP  = 2'd2
  } arb_state_t;

  // Widest request vector the search helper handles; callers zero-extend into it.
  localparam int unsigned MAX_REQ = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } pick_t;

  // First set request at or after ptr, wrapping modulo nreq.
  // ptr must be below nreq, so one conditional subtraction suffices for the wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input int unsigned        ptr,
                                    input int unsigned        nreq);
    pick_t       res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = ptr + i;
      if (k >= nreq) k = k - nreq;
      if ((i < nreq) && !res.found && req[k[4:0]]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sum_accum.sv
// Unsigned accumulator with a sticky overflow flag; once a carry occurs the
// wrapped value at that point is frozen until the next clear.
module sum_accum
  #(parameter int W = 16)
  (
    input  logic         ck,
    input  logic         reset_l,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] data,
    output logic [W-1:0] acc,
    output logic         ovf
  );

  logic [W:0] sum;

  // One extra bit catches the carry out of the W-bit add.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, data};
  end

  // Clear wins over add; adds stop once overflow has been seen.
  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en && !ovf) begin
      acc <= sum[W-1:0];
      if (sum[W]) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/sum_share_arbiter.sv
// Round-robin arbiter sharing one zero-terminated summing datapath among
// NREQ requesters. NREQ must not exceed sum_arb_pkg::MAX_REQ.
module sum_share_arbiter
  import sum_arb_pkg::*;
  #(
    parameter  int NREQ = 4,
    parameter  int W    = 16,
    localparam int IDW  = $clog2(NREQ)
  )
  (
    input  logic            ck,
    input  logic            reset_l,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    input  logic            valid,
    input  logic [W-1:0]    data_in,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_sum,
    output logic            rsp_error,
    output logic            busy
  );

  arb_state_t           state;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       cur_id;
  logic [MAX_REQ-1:0]   req_ext;
  pick_t                pick;
  logic [IDW-1:0]       pick_idx;
  logic                 start;
  logic                 owner_req;
  logic                 abort;
  logic                 term;
  logic                 add_en;
  logic [W-1:0]         acc;
  logic                 ovf;

  // Arbitration search and per-cycle decode of the granted requester's stream.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick               = rr_pick(req_ext, 32'(rr_ptr), NREQ);
    pick_idx           = IDW'(pick.idx);
    start              = (state == S_IDLE) && pick.found;
    owner_req          = req[cur_id];
    // Losing the request takes priority over anything on the data bus.
    abort              = (state == S_ACC) && !owner_req;
    term               = (state == S_ACC) && owner_req && valid && (data_in == '0);
    add_en             = (state == S_ACC) && owner_req && valid && (data_in != '0);
  end

  sum_accum #(.W(W)) u_accum (
    .ck      (ck),
    .reset_l (reset_l),
    .clr     (start),
    .add_en  (add_en),
    .data    (data_in),
    .acc     (acc),
    .ovf     (ovf)
  );

  // Control FSM: grant, pointer advance on grant, release on abort or terminator.
  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      gnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick.found) begin
            state  <= S_ACC;
            cur_id <= pick_idx;
            gnt    <= NREQ'(1) << pick_idx;
            rr_ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        S_ACC: begin
          if (abort) begin
            state <= S_IDLE;
            gnt   <= '0;
          end else if (term) begin
            state <= S_RSP;
            gnt   <= '0;
          end
        end
        S_RSP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // Response fields are captured at the terminator and held until the next one.
  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_error <= 1'b0;
    end else if (term) begin
      rsp_id    <= cur_id;
      rsp_sum   <= acc;
      rsp_error <= ovf;
    end
  end

  assign rsp_valid = (state == S_RSP);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sum_share_arbiter.sv
// Directed bench for sum_share_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge that updated them.
module tb_sum_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic            ck = 1'b0;
  logic            reset_l;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            valid;
  logic [W-1:0]    data_in;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_error;
  logic            busy;

  int checks = 0;
  int passed = 0;

  sum_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .ck        (ck),
    .reset_l   (reset_l),
    .req       (req),
    .gnt       (gnt),
    .valid     (valid),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_error (rsp_error),
    .busy      (busy)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ck);
  endtask

  task automatic send(input logic [W-1:0] w);
    valid   = 1'b1;
    data_in = w;
    @(negedge ck);
  endtask

  task automatic chk_rsp(input string tag, input logic [IDW-1:0] id,
                         input logic [W-1:0] sum, input logic err);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_rsp_sum"},   32'(rsp_sum),   32'(sum));
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'(err));
    chk({tag, "_gnt_rsp"},   32'(gnt),       32'd0);
    $display("txn %s: id=%0d sum=0x%0h error=%0b", tag, rsp_id, rsp_sum, rsp_error);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_l = 1'b0;
    req     = '0;
    valid   = 1'b0;
    data_in = '0;
    tick();
    tick();
    chk("rst_gnt",       32'(gnt),       32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_sum",   32'(rsp_sum),   32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    reset_l = 1'b1;
    tick();
    chk("idle_no_req_gnt", 32'(gnt), 32'd0);

    // T2: all requesting, each sends 1,0; grants rotate 0,1,2,3,0.
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t2_gnt",    32'(gnt),         32'(4'b0001 << (k % 4)));
      chk("t2_onehot", 32'($onehot(gnt)), 32'd1);
      send(16'd1);
      chk("t2_onehot_acc", 32'($onehot(gnt)), 32'd1);
      send(16'd0);
      chk_rsp("t2", IDW'(k % 4), 16'd1, 1'b0);
      valid = 1'b0;
      if (k == 4) req = '0;
      tick();
      chk("t2_idle_gnt",   32'(gnt),       32'd0);
      chk("t2_rsp_pulse",  32'(rsp_valid), 32'd0);
      tick();
    end
    chk("t2_end_busy", 32'(busy), 32'd0);

    // T1: requester 2 alone sends 5,7,0 (rr_ptr=1 here).
    req = 4'b0100;
    tick();
    chk("t1_gnt",  32'(gnt),  32'h4);
    chk("t1_busy", 32'(busy), 32'd1);
    send(16'd5);
    send(16'd7);
    send(16'd0);
    chk_rsp("t1", 2'd2, 16'd12, 1'b0);
    valid = 1'b0;
    req   = '0;
    tick();
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("t1_sum_hold",  32'(rsp_sum),   32'd12);
    chk("t1_busy_idle", 32'(busy),      32'd0);

    // T3: overflow on requester 3; word after the overflow is ignored.
    req = 4'b1000;
    tick();
    chk("t3_gnt", 32'(gnt), 32'h8);
    send(16'hFFF0);
    send(16'h0020);
    send(16'h0005);
    send(16'h0000);
    chk_rsp("t3", 2'd3, 16'h0010, 1'b1);
    valid = 1'b0;
    req   = '0;
    tick();

    // T4: sum exactly 2^W-1, then a fresh transaction with ovf cleared.
    req = 4'b0001;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h1);
    send(16'hFFFE);
    send(16'h0001);
    send(16'h0000);
    chk_rsp("t4a", 2'd0, 16'hFFFF, 1'b0);
    valid = 1'b0;
    tick();
    tick();
    chk("t4_regnt", 32'(gnt), 32'h1);
    send(16'd3);
    send(16'd0);
    chk_rsp("t4b", 2'd0, 16'd3, 1'b0);
    valid = 1'b0;
    req   = '0;
    tick();

    // T5: requester 1 aborts after 9,9; then 1 and 3 together -> 3 wins.
    req = 4'b0010;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h2);
    send(16'd9);
    send(16'd9);
    valid = 1'b0;
    req   = '0;
    tick();
    chk("t5_abort_gnt",       32'(gnt),       32'd0);
    chk("t5_abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_abort_busy",      32'(busy),      32'd0);
    chk("t5_abort_sum_hold",  32'(rsp_sum),   32'd3);
    req = 4'b1010;
    tick();
    chk("t5_rr_gnt", 32'(gnt), 32'h8);
    // Terminator and request drop together: abort wins.
    send(16'd4);
    valid   = 1'b1;
    data_in = 16'd0;
    req     = '0;
    tick();
    chk("t5_aw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_aw_gnt",       32'(gnt),       32'd0);
    chk("t5_aw_busy",      32'(busy),      32'd0);
    chk("t5_aw_sum_hold",  32'(rsp_sum),   32'd3);
    valid = 1'b0;
    tick();
    chk("t5_aw_no_late_rsp", 32'(rsp_valid), 32'd0);

    // T6: asynchronous reset mid-transaction, then requester 3 alone.
    req = 4'b0001;
    tick();
    chk("t6_gnt", 32'(gnt), 32'h1);
    send(16'd7);
    #2 reset_l = 1'b0;
    #1;
    chk("t6_rst_gnt",       32'(gnt),       32'd0);
    chk("t6_rst_rsp_sum",   32'(rsp_sum),   32'd0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_busy",      32'(busy),      32'd0);
    tick();
    reset_l = 1'b1;
    valid   = 1'b0;
    req     = 4'b1000;
    tick();
    chk("t6_post_gnt", 32'(gnt), 32'h8);
    send(16'd0);
    chk_rsp("t6_first_term", 2'd3, 16'd0, 1'b0);
    valid = 1'b0;
    req   = '0;
    tick();
    chk("t6_end_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
